// File: rtl/osd_uart_bb_host_pkg.sv
// Shared definitions for the OSD UART bb-bus host: 16550 register map,
// LSR bit positions and the host FSM state encoding.
package osd_dem_uart_package;

  localparam logic [3:0] UART_RBR_THR = 4'd0;
  localparam logic [3:0] UART_IER     = 4'd1;
  localparam logic [3:0] UART_LSR     = 4'd5;

  localparam int LSR_DR   = 0;
  localparam int LSR_THRE = 5;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_POLL,
    ST_LSR_WAIT,
    ST_RBR_RD,
    ST_RBR_WAIT,
    ST_THR_WR
  } uart_host_state_t;

endpackage

// File: rtl/osd_uart_bb_host_if.sv
// bb register bus between the UART host (master) and a 16550-style register responder (slave).
// Every access is a single-cycle strobe; read data returns on the following cycle.
interface osd_uart_bb_host_if #(
  parameter int DW = 32
) ();

  logic [3:0]    bb_addr_o;
  logic [DW-1:0] bb_dout_o;
  logic          bb_en_o;
  logic          bb_we_o;
  logic [DW-1:0] bb_din_i;

  modport master (
    output bb_addr_o, bb_dout_o, bb_en_o, bb_we_o,
    input  bb_din_i
  );

  modport slave (
    input  bb_addr_o, bb_dout_o, bb_en_o, bb_we_o,
    output bb_din_i
  );

endinterface

// File: rtl/osd_uart_bb_host.sv
// Polls a 16550-style UART over the bb bus, moving bytes between it and tx/rx valid-ready streams.
// tx is accepted only once THRE is seen; rx holds one byte and stops reading RBR until it is taken.
module osd_uart_bb_host
  import osd_dem_uart_package::*;
#(
  parameter int DW            = 32,
  parameter int POLL_INTERVAL = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tx_valid,
  input  logic [7:0]         tx_char,
  output logic               tx_ready,
  output logic               rx_valid,
  output logic [7:0]         rx_char,
  input  logic               rx_ready,
  input  logic               irq_i,
  osd_uart_bb_host_if.master bb,
  output logic               busy
);

  localparam int CW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(POLL_INTERVAL - 1);

  uart_host_state_t state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       rx_char_q, rx_char_d;

  logic             acc_en, acc_we, tx_ready_raw;
  logic [3:0]       acc_addr;
  logic [7:0]       wr_byte;
  logic [7:0]       din_byte;

  assign din_byte = bb.bb_din_i[7:0];

  generate
    if (DW > 8) begin : g_din_hi
      logic unused_din_hi;
      assign unused_din_hi = ^bb.bb_din_i[DW-1:8];
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_en       = 1'b0;
    acc_we       = 1'b0;
    acc_addr     = UART_RBR_THR;
    wr_byte      = 8'h00;
    tx_ready_raw = 1'b0;
    rx_valid_d   = rx_valid_q && !rx_ready;
    rx_char_d    = rx_char_q;

    unique case (state_q)
      ST_INIT: begin
        acc_en   = 1'b1;
        acc_we   = 1'b1;
        acc_addr = UART_IER;
        state_d  = ST_IDLE;
      end
      ST_IDLE: begin
        if (cnt_q == CNT_LAST || irq_i || tx_valid) begin
          cnt_d   = '0;
          state_d = ST_POLL;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_POLL: begin
        acc_en   = 1'b1;
        acc_addr = UART_LSR;
        state_d  = ST_LSR_WAIT;
      end
      ST_LSR_WAIT: begin
        // A full slot masks DR; the UART keeps the byte until the next poll.
        if (din_byte[LSR_DR] && !rx_valid_q) begin
          state_d = ST_RBR_RD;
        end else if (din_byte[LSR_THRE] && tx_valid) begin
          state_d = ST_THR_WR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RBR_RD: begin
        acc_en  = 1'b1;
        state_d = ST_RBR_WAIT;
      end
      ST_RBR_WAIT: begin
        rx_valid_d = 1'b1;
        rx_char_d  = din_byte;
        state_d    = ST_IDLE;
      end
      ST_THR_WR: begin
        acc_en       = 1'b1;
        acc_we       = 1'b1;
        wr_byte      = tx_char;
        tx_ready_raw = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      rx_valid_q <= 1'b0;
      rx_char_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_valid_q <= rx_valid_d;
      rx_char_q  <= rx_char_d;
    end
  end

  // Reset parks the FSM in INIT, whose strobe must stay quiet until release.
  assign bb.bb_en_o   = rst & acc_en;
  assign bb.bb_we_o   = rst & acc_we;
  assign bb.bb_addr_o = rst ? acc_addr : 4'h0;
  assign bb.bb_dout_o = rst ? {(DW/8){wr_byte}} : '0;
  assign tx_ready     = rst & tx_ready_raw;
  assign busy         = rst & (state_q != ST_IDLE);
  assign rx_valid     = rx_valid_q;
  assign rx_char      = rx_char_q;

endmodule

// File: tb/tb_osd_uart_bb_host.sv
// Scoreboard bench for osd_uart_bb_host: a register responder model plus per-scenario tasks.
module tb_osd_uart_bb_host;
  import osd_dem_uart_package::*;

  localparam int DW = 32;
  localparam int PI = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_char = 8'h00;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_char;
  logic       rx_ready = 1'b0;
  logic       irq = 1'b0;
  logic       busy;
  logic [7:0] lsr_val = 8'h00;
  logic [7:0] rbr_val = 8'h00;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int txr_cnt = 0;
  int txr_bad = 0;

  typedef struct {
    logic [3:0]    addr;
    logic          we;
    logic [DW-1:0] dout;
    logic          txr;
    int            cyc;
  } acc_t;

  acc_t       obs_q[$];
  acc_t       exp_q[$];
  logic [7:0] rx_obs_q[$];
  logic [7:0] rx_exp_q[$];

  osd_uart_bb_host_if #(.DW(DW)) bus ();

  osd_uart_bb_host #(.DW(DW), .POLL_INTERVAL(PI)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_valid (tx_valid),
    .tx_char  (tx_char),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .rx_char  (rx_char),
    .rx_ready (rx_ready),
    .irq_i    (irq),
    .bb       (bus),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder: read data appears the cycle after the request; upper lanes are junk.
  always @(posedge clk or negedge rst) begin
    if (!rst) bus.bb_din_i <= '0;
    else if (bus.bb_en_o === 1'b1 && bus.bb_we_o === 1'b0)
      bus.bb_din_i <= {{(DW-8){1'b1}}, (bus.bb_addr_o == UART_LSR) ? lsr_val :
                       (bus.bb_addr_o == UART_RBR_THR) ? rbr_val : 8'h00};
  end

  always @(negedge clk) begin
    acc_t m;
    if (bus.bb_en_o === 1'b1) begin
      m.addr = bus.bb_addr_o; m.we = bus.bb_we_o; m.dout = bus.bb_dout_o;
      m.txr = tx_ready; m.cyc = cyc;
      obs_q.push_back(m);
    end
    if (tx_ready === 1'b1) begin
      txr_cnt++;
      if (!(bus.bb_en_o === 1'b1 && bus.bb_we_o === 1'b1 && bus.bb_addr_o === UART_RBR_THR)) txr_bad++;
    end
    if (rx_valid === 1'b1 && rx_ready === 1'b1) rx_obs_q.push_back(rx_char);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  function automatic acc_t mk(logic [3:0] a, logic w, logic [7:0] b, logic t, int c);
    acc_t r;
    r.addr = a; r.we = w; r.dout = {(DW/8){b}}; r.txr = t; r.cyc = c;
    return r;
  endfunction

  task automatic get_acc(output acc_t a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (obs_q.size() > 0) break;
      @(negedge clk); #1;
    end
    if (obs_q.size() > 0) begin
      a = obs_q.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic wait_idle();
    @(negedge clk); #1;
    for (int i = 0; i < 100; i++) begin
      if (busy === 1'b0) break;
      @(negedge clk); #1;
    end
  endtask

  task automatic consume_rx();
    @(posedge clk); #1 rx_ready = 1'b1;
    @(posedge clk); #1 rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    acc_t got, e;
    bit ok;
    int rel;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({tx_ready, rx_valid, busy, bus.bb_en_o, bus.bb_we_o} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: {tx_ready,rx_valid,busy,en,we}=%b, required 00000",
               {tx_ready, rx_valid, busy, bus.bb_en_o, bus.bb_we_o});
    end
    n_cmp++;
    if (rx_char !== 8'h00) begin
      n_bad++; $display("FAIL reset_rx_char: got %h, required 00", rx_char);
    end
    n_cmp++;
    if (bus.bb_addr_o !== 4'h0 || bus.bb_dout_o !== {DW{1'b0}}) begin
      n_bad++; $display("FAIL reset_bus: addr=%h dout=%h, required 0/0", bus.bb_addr_o, bus.bb_dout_o);
    end
    obs_q.delete();
    @(posedge clk); #2;
    rst = 1'b1;
    rel = cyc;
    exp_q.push_back(mk(UART_IER, 1'b1, 8'h00, 1'b0, rel));
    exp_q.push_back(mk(UART_LSR, 1'b0, 8'h00, 1'b0, rel + PI + 1));
    @(negedge clk); @(negedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || bus.bb_en_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_idle: busy=%b en=%b, required 0/0", busy, bus.bb_en_o);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_acc(got, ok);
      n_cmp++;
      if (!ok || got.addr !== e.addr || got.we !== e.we || got.dout !== e.dout ||
          got.txr !== e.txr || (e.cyc >= 0 && got.cyc != e.cyc)) begin
        n_bad++;
        $display("FAIL reset_seq: got ok=%0b addr=%0d we=%b dout=%h txr=%b cyc=%0d, required addr=%0d we=%b dout=%h txr=%b cyc=%0d",
                 ok, got.addr, got.we, got.dout, got.txr, got.cyc, e.addr, e.we, e.dout, e.txr, e.cyc);
      end
    end
  endtask

  task automatic test_tx();
    acc_t got, e;
    bit ok;
    int base;
    wait_idle();
    obs_q.delete();
    base = txr_cnt;
    lsr_val = 8'h20; tx_char = 8'h41; tx_valid = 1'b1;
    exp_q.push_back(mk(UART_LSR, 1'b0, 8'h00, 1'b0, -1));
    exp_q.push_back(mk(UART_RBR_THR, 1'b1, 8'h41, 1'b1, -1));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_acc(got, ok);
      if (got.we === 1'b1) tx_valid = 1'b0;
      n_cmp++;
      if (!ok || got.addr !== e.addr || got.we !== e.we || got.dout !== e.dout || got.txr !== e.txr) begin
        n_bad++;
        $display("FAIL tx_seq: got ok=%0b addr=%0d we=%b dout=%h txr=%b, required addr=%0d we=%b dout=%h txr=%b",
                 ok, got.addr, got.we, got.dout, got.txr, e.addr, e.we, e.dout, e.txr);
      end
    end
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (txr_cnt - base != 1 || tx_ready !== 1'b0) begin
      n_bad++; $display("FAIL tx_ready_pulse: pulses=%0d now=%b, required 1 pulse then 0", txr_cnt - base, tx_ready);
    end
  endtask

  task automatic test_rx();
    acc_t got, e;
    bit ok;
    int rbr_reads, polls;
    logic [7:0] ob, ex;
    wait_idle();
    obs_q.delete();
    lsr_val = 8'h01; rbr_val = 8'h5A; rx_ready = 1'b0;
    rx_exp_q.push_back(8'h5A);
    exp_q.push_back(mk(UART_LSR, 1'b0, 8'h00, 1'b0, -1));
    exp_q.push_back(mk(UART_RBR_THR, 1'b0, 8'h00, 1'b0, -1));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_acc(got, ok);
      n_cmp++;
      if (!ok || got.addr !== e.addr || got.we !== e.we || got.dout !== e.dout || got.txr !== e.txr) begin
        n_bad++;
        $display("FAIL rx_seq: got ok=%0b addr=%0d we=%b dout=%h, required addr=%0d we=%b dout=%h",
                 ok, got.addr, got.we, got.dout, e.addr, e.we, e.dout);
      end
    end
    @(negedge clk); @(negedge clk); #1;
    n_cmp++;
    if (rx_valid !== 1'b1 || rx_char !== 8'h5A) begin
      n_bad++; $display("FAIL rx_hold: rx_valid=%b rx_char=%h, required 1/5a", rx_valid, rx_char);
    end
    obs_q.delete();
    repeat (100) @(negedge clk);
    #1;
    rbr_reads = 0; polls = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i].addr == UART_RBR_THR) rbr_reads++;
      else if (obs_q[i].addr == UART_LSR) polls++;
    end
    n_cmp++;
    if (rbr_reads != 0 || polls < 4) begin
      n_bad++; $display("FAIL rx_full_slot: rbr_reads=%0d polls=%0d, required 0 and >=4", rbr_reads, polls);
    end
    n_cmp++;
    if (rx_valid !== 1'b1 || rx_char !== 8'h5A) begin
      n_bad++; $display("FAIL rx_stable: rx_valid=%b rx_char=%h, required 1/5a", rx_valid, rx_char);
    end
    lsr_val = 8'h00;
    repeat (3) @(negedge clk);
    consume_rx();
    n_cmp++;
    if (rx_valid !== 1'b0) begin
      n_bad++; $display("FAIL rx_clear: rx_valid=%b after handshake, required 0", rx_valid);
    end
    ex = rx_exp_q.pop_front();
    ob = 8'hxx;
    if (rx_obs_q.size() > 0) ob = rx_obs_q.pop_front();
    n_cmp++;
    if (ob !== ex) begin
      n_bad++; $display("FAIL rx_data: consumed %h, required %h", ob, ex);
    end
  endtask

  task automatic test_simul();
    acc_t got, e;
    bit ok;
    int base;
    logic [7:0] ob, ex;
    wait_idle();
    obs_q.delete();
    base = txr_cnt;
    lsr_val = 8'h21; rbr_val = 8'h77; tx_char = 8'h33; tx_valid = 1'b1;
    rx_exp_q.push_back(8'h77);
    exp_q.push_back(mk(UART_LSR, 1'b0, 8'h00, 1'b0, -1));
    exp_q.push_back(mk(UART_RBR_THR, 1'b0, 8'h00, 1'b0, -1));
    exp_q.push_back(mk(UART_LSR, 1'b0, 8'h00, 1'b0, -1));
    exp_q.push_back(mk(UART_RBR_THR, 1'b1, 8'h33, 1'b1, -1));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_acc(got, ok);
      if (got.we === 1'b1) tx_valid = 1'b0;
      n_cmp++;
      if (!ok || got.addr !== e.addr || got.we !== e.we || got.dout !== e.dout || got.txr !== e.txr) begin
        n_bad++;
        $display("FAIL simul_seq: got ok=%0b addr=%0d we=%b dout=%h txr=%b, required addr=%0d we=%b dout=%h txr=%b",
                 ok, got.addr, got.we, got.dout, got.txr, e.addr, e.we, e.dout, e.txr);
      end
    end
    tx_valid = 1'b0;
    lsr_val = 8'h00;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (txr_cnt - base != 1) begin
      n_bad++; $display("FAIL simul_tx_ready: pulses=%0d, required 1", txr_cnt - base);
    end
    consume_rx();
    ex = rx_exp_q.pop_front();
    ob = 8'hxx;
    if (rx_obs_q.size() > 0) ob = rx_obs_q.pop_front();
    n_cmp++;
    if (ob !== ex) begin
      n_bad++; $display("FAIL simul_rx_data: consumed %h, required %h", ob, ex);
    end
  endtask

  task automatic test_irq();
    acc_t got;
    bit ok;
    int c;
    wait_idle();
    lsr_val = 8'h00;
    obs_q.delete();
    get_acc(got, ok);
    c = got.cyc;
    // Poll at c, LSR_WAIT at c+1, IDLE counter 0..3 over c+2..c+5.
    repeat (5) @(posedge clk);
    #1 irq = 1'b1;
    @(posedge clk);
    #1 irq = 1'b0;
    get_acc(got, ok);
    n_cmp++;
    if (!ok || got.addr !== UART_LSR || got.we !== 1'b0 || got.cyc != c + 6) begin
      n_bad++; $display("FAIL irq_early_poll: ok=%0b addr=%0d cyc=%0d, required addr=5 cyc=%0d", ok, got.addr, got.cyc, c + 6);
    end
    irq = 1'b1;
    @(posedge clk);
    #1 irq = 1'b0;
    get_acc(got, ok);
    n_cmp++;
    if (!ok || got.addr !== UART_LSR || got.cyc != c + 6 + PI + 2) begin
      n_bad++; $display("FAIL irq_restart: ok=%0b addr=%0d cyc=%0d, required addr=5 cyc=%0d", ok, got.addr, got.cyc, c + 6 + PI + 2);
    end
    c = got.cyc;
    irq = 1'b1;
    get_acc(got, ok);
    n_cmp++;
    if (!ok || got.addr !== UART_LSR || got.cyc != c + 3) begin
      n_bad++; $display("FAIL irq_level: ok=%0b addr=%0d cyc=%0d, required addr=5 cyc=%0d", ok, got.addr, got.cyc, c + 3);
    end
    irq = 1'b0;
  endtask

  task automatic test_reset_thr();
    acc_t got, e;
    bit ok;
    int rel;
    wait_idle();
    obs_q.delete();
    rx_ready = 1'b0;
    lsr_val = 8'h21; rbr_val = 8'h99; tx_char = 8'h5C; tx_valid = 1'b1;
    exp_q.push_back(mk(UART_LSR, 1'b0, 8'h00, 1'b0, -1));
    exp_q.push_back(mk(UART_RBR_THR, 1'b0, 8'h00, 1'b0, -1));
    exp_q.push_back(mk(UART_LSR, 1'b0, 8'h00, 1'b0, -1));
    exp_q.push_back(mk(UART_RBR_THR, 1'b1, 8'h5C, 1'b1, -1));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_acc(got, ok);
      if (got.we === 1'b1) rst = 1'b0;
      n_cmp++;
      if (!ok || got.addr !== e.addr || got.we !== e.we || got.dout !== e.dout || got.txr !== e.txr) begin
        n_bad++;
        $display("FAIL rst_thr_seq: got ok=%0b addr=%0d we=%b dout=%h, required addr=%0d we=%b dout=%h",
                 ok, got.addr, got.we, got.dout, e.addr, e.we, e.dout);
      end
    end
    #1;
    n_cmp++;
    if (tx_ready !== 1'b0 || bus.bb_en_o !== 1'b0 || busy !== 1'b0 || rx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_thr_abort: tx_ready=%b en=%b busy=%b rx_valid=%b, required all 0",
               tx_ready, bus.bb_en_o, busy, rx_valid);
    end
    tx_valid = 1'b0; lsr_val = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (rx_char !== 8'h00) begin
      n_bad++; $display("FAIL rst_thr_rx_char: got %h, required 00", rx_char);
    end
    obs_q.delete();
    @(posedge clk); #2;
    rst = 1'b1;
    rel = cyc;
    exp_q.push_back(mk(UART_IER, 1'b1, 8'h00, 1'b0, rel));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_acc(got, ok);
      n_cmp++;
      if (!ok || got.addr !== e.addr || got.we !== e.we || got.dout !== e.dout || got.cyc != e.cyc) begin
        n_bad++;
        $display("FAIL rst_thr_init: got ok=%0b addr=%0d we=%b dout=%h cyc=%0d, required addr=%0d we=%b dout=%h cyc=%0d",
                 ok, got.addr, got.we, got.dout, got.cyc, e.addr, e.we, e.dout, e.cyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_rx();
    test_simul();
    test_irq();
    test_reset_thr();
    n_cmp++;
    if (txr_bad != 0) begin
      n_bad++; $display("FAIL tx_ready_outside_write: %0d cycles, required 0", txr_bad);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/osd_uart_bb_host.md
OSD_UART_BB_HOST -- requirements
Module: osd_uart_bb_host

Interface
REQ-001 Parameter DW, default 32, bus data width; must be at least 8.
REQ-002 Parameter POLL_INTERVAL, default 16, number of idle cycles between Line Status Register (LSR) polls; must be at least 1.
REQ-003 Port clk, input, 1, single clock for the whole block.
REQ-004 Port rst, input, 1, reset; asynchronous, active-low.
REQ-005 Port tx_valid, input, 1, a character is offered for transmission.
REQ-006 Port tx_char, input, 8, character to transmit.
REQ-007 Port tx_ready, output, 1, character accepted when tx_valid && tx_ready.
REQ-008 Port rx_valid, output, 1, a received character is held.
REQ-009 Port rx_char, output, 8, the held received character.
REQ-010 Port rx_ready, input, 1, consumer takes the character when rx_valid && rx_ready.
REQ-011 Port irq_i, input, 1, UART interrupt; forces an early poll.
REQ-012 Port bb_addr_o, output, 4, register address.
REQ-013 Port bb_dout_o, output, DW, write data.
REQ-014 Port bb_en_o, output, 1, bus request strobe.
REQ-015 Port bb_we_o, output, 1, write qualifier.
REQ-016 Port bb_din_i, input, DW, read data; only bits [7:0] are used.
REQ-017 Port busy, output, 1, high in every state except IDLE.

Function
REQ-018 The block shall be the initiator for the 16550-style bb bus; it drives a UART register responder on behalf of byte streams.
REQ-019 Every bus access shall last exactly one cycle with bb_en_o=1; a write takes effect in that cycle.
REQ-020 For a read, bb_din_i[7:0] shall be sampled on the cycle after the request.
REQ-021 bb_dout_o shall carry the write byte replicated across all DW/8 lanes; it shall be 0 when no write is in progress.
REQ-022 bb_en_o and bb_we_o shall be 0 in every cycle without an access.
REQ-023 FSM states and behaviour:
- INIT: write IER (addr 1) = 0x00, then go to IDLE.
- IDLE: count idle cycles; go to POLL when the counter reaches POLL_INTERVAL-1, or when irq_i=1, or when tx_valid=1. Entering POLL clears the counter.
- POLL: read LSR (addr 5), then go to LSR_WAIT.
- LSR_WAIT: capture the status byte.
  - If DR (bit 0) is set and the receive holding slot is empty, go to RBR_RD.
  - Otherwise, if THRE (bit 5) is set and tx_valid=1, go to THR_WR.
  - Otherwise go to IDLE.
- RBR_RD: read RBR (addr 0), then go to RBR_WAIT.
- RBR_WAIT: load the data byte into the receive slot; set rx_valid; go to IDLE.
- THR_WR: write tx_char to THR (addr 0); assert tx_ready for this cycle only; go to IDLE.
REQ-024 Receive has priority over transmit within a single poll; a pending TX character is retried on the next poll.
REQ-025 tx_ready shall be high only in THR_WR; tx_char shall be sampled in that same cycle.
REQ-026 The receive slot shall hold one entry. rx_char shall stay stable while rx_valid=1, and rx_valid shall clear on the cycle after the rx handshake.
REQ-027 A handshake in the same cycle as RBR_WAIT's load is impossible, because the load is gated on the slot being empty.
REQ-028 While the slot is full, DR shall be ignored; no data is lost because the UART keeps the data.
REQ-029 The idle counter shall saturate rather than wrap.
REQ-030 irq_i pulses that arrive outside IDLE shall have no effect; level-held IRQs cause back-to-back polls.

Reset
REQ-031 On rst=0 the FSM shall enter INIT and the counter shall clear; tx_ready, rx_valid, bb_en_o, bb_we_o and busy shall be 0; rx_char, bb_addr_o and bb_dout_o shall be 0.
REQ-032 Reset asserted mid-access shall abort the access with no partial handshake; a held rx character is discarded.
REQ-033 The first bus access after reset release shall be the INIT write, issued in the first clock cycle after release.

Structure
REQ-034 UART register addresses (RBR_THR=0, IER=1, LSR=5), LSR bit indices (DR=0, THRE=5) and the FSM state enum shall live in the shared package osd_dem_uart_package.
REQ-035 The block shall be a single module with no sub-modules; the receive slot is inline registers.

Verification
REQ-036 Reset release: the first access is en=1, we=1, addr=1, dout=0x00000000, then idle for POLL_INTERVAL cycles with no strobes.
REQ-037 TX: tx_valid=1, tx_char=0x41, responder LSR=0x20 → LSR read at addr 5, then a write at addr 0 with dout=0x41414141 and tx_ready pulsed for one cycle.
REQ-038 RX: LSR=0x01, RBR=0x5A → read at addr 0; rx_valid=1 with rx_char=0x5A; holding rx_ready=0 for 100 cycles produces no further RBR reads.
REQ-039 Simultaneous: tx_valid=1, LSR=0x21 → RBR is read first; the THR write follows on the next poll; tx_ready never rises before the THR write.
REQ-040 irq_i pulse at IDLE counter=3 (POLL_INTERVAL=16) → LSR read starts the next cycle and the counter restarts.
REQ-041 Reset asserted in THR_WR → tx_ready=0, bb_en_o=0 immediately; after release the INIT write repeats.
